// File: rtl/imem_loader_pkg.sv
// imem_loader shared types and constants.
// State encoding and word packing geometry.
package imem_loader_pkg;

  localparam int ADDR_W_DEF     = 6;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_WRITE,
    ST_CHECK,
    ST_DONE
  } state_e;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Byte-to-word packer for the IMEM loader.
// Big-endian insert, byte index and running XOR.
module word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic [7:0]  csum_o,
  output logic        word_full_o
);

  localparam logic [1:0] LAST_IDX =
    2'(BYTES_PER_WORD - 1);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  csum_q, csum_d;

  // Next packer contents: clear wins, else insert the accepted byte.
  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    csum_d = csum_q;
    if (clear_i) begin
      idx_d  = '0;
      word_d = '0;
      csum_d = '0;
    end else if (accept_i) begin
      idx_d  = idx_q + 2'd1;
      csum_d = csum_q ^ byte_i;
      unique case (idx_q)
        2'd0: word_d[31:24] = byte_i;
        2'd1: word_d[23:16] = byte_i;
        2'd2: word_d[15:8]  = byte_i;
        2'd3: word_d[7:0]   = byte_i;
        default: word_d = word_q;
      endcase
    end
  end

  // Packer state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q  <= '0;
      word_q <= '0;
      csum_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
      csum_q <= csum_d;
    end
  end

  assign word_o      = word_q;
  assign csum_o      = csum_q;
  assign word_full_o = accept_i & ~clear_i
                     & (idx_q == LAST_IDX);

endmodule

// File: rtl/imem_loader.sv
// Streams a program into IMEM while holding the CPU.
// Bytes -> big-endian words, trailing XOR checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = 32
) (
  input  logic              SYS_clk,
  input  logic              SYS_reset,
  input  logic              LD_start,
  input  logic [ADDR_W-1:0] LD_word_count,
  input  logic [7:0]        LD_byte,
  input  logic              LD_byte_valid,
  output logic              LD_byte_ready,
  output logic [ADDR_W-1:0] IMEM_address,
  output logic [DATA_W-1:0] IMEM_data,
  output logic              IMEM_wren,
  output logic              CPU_hold,
  output logic              LD_busy,
  output logic              LD_done,
  output logic              LD_error
);

  localparam logic [ADDR_W:0] FULL_CNT =
    {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_LEFT =
    (ADDR_W+1)'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   left_q, left_d;
  logic              err_q, err_d;
  logic              ready;
  logic              start_acc;
  logic              recv_acc;
  logic              chk_acc;
  logic              word_full;
  logic              last_word;
  logic [31:0]       word;
  logic [7:0]        csum;

  assign start_acc = (state_q == ST_IDLE) & LD_start;
  assign recv_acc  = (state_q == ST_RECV)
                   & LD_byte_valid & ready;
  assign chk_acc   = (state_q == ST_CHECK)
                   & LD_byte_valid & ready;
  assign last_word = (left_q == ONE_LEFT);

  word_packer u_packer (
    .clk_i       (SYS_clk),
    .rst_ni      (SYS_reset),
    .clear_i     (start_acc),
    .accept_i    (recv_acc),
    .byte_i      (LD_byte),
    .word_o      (word),
    .csum_o      (csum),
    .word_full_o (word_full)
  );

  // State register.
  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (LD_start)  state_d = ST_RECV;
      ST_RECV:  if (word_full) state_d = ST_WRITE;
      ST_WRITE: state_d = last_word ? ST_CHECK
                                    : ST_RECV;
      ST_CHECK: if (chk_acc)   state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the state register only.
  always_comb begin
    ready     = 1'b0;
    IMEM_wren = 1'b0;
    LD_done   = 1'b0;
    CPU_hold  = 1'b1;
    unique case (state_q)
      ST_IDLE:  CPU_hold  = 1'b0;
      ST_RECV:  ready     = 1'b1;
      ST_WRITE: IMEM_wren = 1'b1;
      ST_CHECK: ready     = 1'b1;
      ST_DONE:  LD_done   = 1'b1;
      default:  CPU_hold  = 1'b0;
    endcase
  end

  // Address, remaining-word and error next values.
  always_comb begin
    addr_d = addr_q;
    left_d = left_q;
    err_d  = err_q;
    if (start_acc) begin
      addr_d = '0;
      err_d  = 1'b0;
      left_d = (LD_word_count == '0) ? FULL_CNT
             : {1'b0, LD_word_count};
    end
    if (state_q == ST_WRITE) begin
      addr_d = addr_q + ADDR_W'(1);
      left_d = left_q - ONE_LEFT;
    end
    if (chk_acc && (LD_byte != csum)) err_d = 1'b1;
  end

  // Session datapath registers.
  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      addr_q <= '0;
      left_q <= '0;
      err_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      left_q <= left_d;
      err_q  <= err_d;
    end
  end

  assign LD_byte_ready = ready;
  assign IMEM_address  = addr_q;
  assign IMEM_data     = word;
  assign LD_busy       = (state_q != ST_IDLE);
  assign LD_error      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader.
// Byte-stream sessions with hand-computed IMEM writes.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ld_start;
  logic [5:0] ld_count;
  logic [7:0] ld_byte;
  logic       ld_valid;
  logic       ld_ready;
  logic [5:0] imem_addr;
  logic [31:0] imem_data;
  logic       imem_wren;
  logic       cpu_hold;
  logic       ld_busy;
  logic       ld_done;
  logic       ld_error;

  int vecs = 0;
  int miss = 0;

  logic [5:0]  wr_a[$];
  logic [31:0] wr_d[$];
  int          done_cnt = 0;
  int          busy_cyc = 0;

  always #5 clk = ~clk;

  imem_loader dut (
    .SYS_clk       (clk),
    .SYS_reset     (rst_n),
    .LD_start      (ld_start),
    .LD_word_count (ld_count),
    .LD_byte       (ld_byte),
    .LD_byte_valid (ld_valid),
    .LD_byte_ready (ld_ready),
    .IMEM_address  (imem_addr),
    .IMEM_data     (imem_data),
    .IMEM_wren     (imem_wren),
    .CPU_hold      (cpu_hold),
    .LD_busy       (ld_busy),
    .LD_done       (ld_done),
    .LD_error      (ld_error)
  );

  always @(negedge clk) begin
    if (imem_wren) begin
      wr_a.push_back(imem_addr);
      wr_d.push_back(imem_data);
    end
    if (ld_done) done_cnt++;
    if (ld_busy) busy_cyc++;
  end

  task automatic start_sess(input logic [5:0] c);
    wr_a.delete();
    wr_d.delete();
    done_cnt = 0;
    busy_cyc = 0;
    @(negedge clk);
    ld_start = 1'b1;
    ld_count = c;
    @(posedge clk);
    #1;
    ld_start = 1'b0;
    vecs++;
    if ({cpu_hold, ld_busy} !== 2'b11) begin
      miss++;
      $display("FAIL hold_on_start: got %b want 11",
               {cpu_hold, ld_busy});
    end
  endtask

  task automatic drive_bytes(input logic [7:0] b[$],
                             input bit tog,
                             input int start_at);
    int i = 0;
    int cyc = 0;
    bit ph = 1'b0;
    while (i < b.size() && cyc < 2000) begin
      @(negedge clk);
      if (i == start_at) begin
        ld_start = 1'b1;
        ld_count = 6'd5;
      end else begin
        ld_start = 1'b0;
      end
      if (tog && ph) begin
        ld_valid = 1'b0;
      end else begin
        ld_valid = 1'b1;
        ld_byte  = b[i];
      end
      ph = ~ph;
      #1;
      if (ld_valid && ld_ready) i++;
      cyc++;
    end
    @(negedge clk);
    ld_valid = 1'b0;
    ld_start = 1'b0;
    vecs++;
    if (i != b.size()) begin
      miss++;
      $display("FAIL stream: accepted %0d want %0d",
               i, b.size());
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (ld_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    #1;
    vecs++;
    if (ld_busy !== 1'b0) begin
      miss++;
      $display("FAIL idle_timeout: busy=%b want 0", ld_busy);
    end
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    ld_start = 1'b0;
    ld_count = '0;
    ld_byte  = '0;
    ld_valid = 1'b0;
    repeat (2) @(negedge clk);
    if ({ld_ready, imem_wren, cpu_hold, ld_busy,
         ld_done, ld_error} !== 6'b0) begin
      miss++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {ld_ready, imem_wren, cpu_hold, ld_busy,
                ld_done, ld_error});
    end
    vecs++;
    if ({imem_addr, imem_data} !== 38'h0) begin
      miss++;
      $display("FAIL reset_data: got %h/%h want 0/0",
               imem_addr, imem_data);
    end
    vecs++;
    rst_n = 1'b1;
    @(negedge clk);
    if (ld_busy !== 1'b0) begin
      miss++;
      $display("FAIL idle_after_reset: busy=%b want 0",
               ld_busy);
    end
    vecs++;
  endtask

  task automatic test_basic();
    logic [7:0] q[$];
    q = '{8'h20, 8'h08, 8'h00, 8'h05,
          8'h20, 8'h09, 8'h00, 8'h07, 8'h03};
    start_sess(6'd2);
    drive_bytes(q, 1'b0, -1);
    wait_idle();
    chk("basic_nwr", wr_a.size(), 2);
    if (wr_a.size() == 2) begin
      chk("basic_a0", 32'(wr_a[0]), 0);
      chk("basic_d0", wr_d[0], 32'h20080005);
      chk("basic_a1", 32'(wr_a[1]), 1);
      chk("basic_d1", wr_d[1], 32'h20090007);
    end
    chk("basic_done", done_cnt, 1);
    chk("basic_err", 32'(ld_error), 0);
    chk("basic_cycles", busy_cyc, 12);
    chk("basic_hold_off", 32'(cpu_hold), 0);
    chk("basic_final_addr", 32'(imem_addr), 2);
  endtask

  task automatic test_bad_csum();
    logic [7:0] q[$];
    logic [7:0] r[$];
    q = '{8'h20, 8'h08, 8'h00, 8'h05,
          8'h20, 8'h09, 8'h00, 8'h07, 8'h04};
    r = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h2d};
    start_sess(6'd2);
    drive_bytes(q, 1'b0, -1);
    wait_idle();
    chk("bad_nwr", wr_a.size(), 2);
    chk("bad_err_set", 32'(ld_error), 1);
    chk("bad_done", done_cnt, 1);
    start_sess(6'd1);
    chk("bad_err_cleared", 32'(ld_error), 0);
    drive_bytes(r, 1'b0, -1);
    wait_idle();
    chk("bad_next_err", 32'(ld_error), 0);
  endtask

  task automatic test_toggle();
    logic [7:0] q[$];
    q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h2d};
    start_sess(6'd1);
    drive_bytes(q, 1'b1, -1);
    wait_idle();
    chk("tog_nwr", wr_a.size(), 1);
    if (wr_a.size() == 1)
      chk("tog_d0", wr_d[0], 32'h20080005);
    chk("tog_done", done_cnt, 1);
    chk("tog_err", 32'(ld_error), 0);
  endtask

  task automatic test_full();
    logic [7:0] q[$];
    int bad = 0;
    logic [7:0] k8;
    for (int k = 0; k < 256; k++) q.push_back(8'(k));
    q.push_back(8'h00);
    start_sess(6'd0);
    drive_bytes(q, 1'b0, -1);
    wait_idle();
    chk("full_nwr", wr_a.size(), 64);
    for (int k = 0; k < wr_a.size(); k++) begin
      k8 = 8'(4 * k);
      if (wr_a[k] !== 6'(k) ||
          wr_d[k] !== {k8, k8 + 8'd1, k8 + 8'd2, k8 + 8'd3})
        bad++;
    end
    chk("full_order", bad, 0);
    chk("full_final_addr", 32'(imem_addr), 0);
    chk("full_err", 32'(ld_error), 0);
  endtask

  task automatic test_reset_mid();
    logic [7:0] q[$];
    logic [7:0] r[$];
    q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09};
    r = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    start_sess(6'd2);
    drive_bytes(q, 1'b0, -1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rmid_ctrl",
        {26'd0, ld_ready, imem_wren, cpu_hold, ld_busy,
         ld_done, ld_error}, 0);
    chk("rmid_data", imem_data, 0);
    chk("rmid_addr", 32'(imem_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    start_sess(6'd1);
    drive_bytes(r, 1'b0, -1);
    wait_idle();
    chk("rmid_fresh_nwr", wr_a.size(), 1);
    if (wr_d.size() == 1)
      chk("rmid_fresh_d0", wr_d[0], 32'h11223344);
    chk("rmid_fresh_err", 32'(ld_error), 0);
  endtask

  task automatic test_start_ignored();
    logic [7:0] q[$];
    q = '{8'h20, 8'h08, 8'h00, 8'h05,
          8'h20, 8'h09, 8'h00, 8'h07, 8'h03};
    start_sess(6'd2);
    drive_bytes(q, 1'b0, 2);
    wait_idle();
    chk("ign_nwr", wr_a.size(), 2);
    if (wr_a.size() == 2) begin
      chk("ign_a1", 32'(wr_a[1]), 1);
      chk("ign_d1", wr_d[1], 32'h20090007);
    end
    chk("ign_done", done_cnt, 1);
    chk("ign_err", 32'(ld_error), 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_csum();
    test_toggle();
    test_full();
    test_reset_mid();
    test_start_ignored();
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, miss);
    $finish;
  end

endmodule
